// File: rtl/video_timing_pattern_gen.sv
// Video timing and test-pattern source.
// Produces HSync/VSync/VDE/blanking timing plus a 24-bit {R,G,B} pattern stream.
// All outputs are registered and describe the counter position of the previous cycle.
module video_timing_pattern_gen #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        i_enable,
  input  logic [1:0]  i_pattern,
  output logic [23:0] o_pixelData,
  output logic        o_HSync,
  output logic        o_VSync,
  output logic        o_VDE,
  output logic        o_HBlank,
  output logic        o_VBlank,
  output logic        o_frameStart
);

  localparam logic [15:0] HA  = 16'(H_ACTIVE);
  localparam logic [15:0] HSS = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HSE = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] HT  = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [15:0] VA  = 16'(V_ACTIVE);
  localparam logic [15:0] VSS = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VSE = 16'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] VT  = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [15:0] BW  = 16'(H_ACTIVE / 8);

  logic [15:0] hcnt, vcnt;
  logic [15:0] bar_cnt;
  logic [2:0]  bar_idx;
  logic [7:0]  frame_q;
  logic [1:0]  pattern_q;

  logic        at_origin, h_last, v_last;
  logic        hblank, vblank, vde, hsync_act, vsync_act;
  logic [1:0]  pat_eff;
  logic [23:0] bar_rgb, pixel;

  // Position decode and pattern selection for the current counter state.
  always_comb begin
    at_origin = (hcnt == 16'd0) && (vcnt == 16'd0);
    h_last    = (hcnt == HT - 16'd1);
    v_last    = (vcnt == VT - 16'd1);
    hblank    = (hcnt >= HA);
    vblank    = (vcnt >= VA);
    vde       = !hblank && !vblank;
    hsync_act = (hcnt >= HSS) && (hcnt < HSE);
    vsync_act = (vcnt >= VSS) && (vcnt < VSE);
    // The pattern latched at (0,0) must already apply to pixel (0,0) itself.
    pat_eff   = at_origin ? i_pattern : pattern_q;

    unique case (bar_idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase

    unique case (pat_eff)
      2'd0:    pixel = bar_rgb;
      2'd1:    pixel = {3{hcnt[7:0]}};
      2'd2:    pixel = (hcnt[5] ^ vcnt[5]) ? 24'hFFFFFF : 24'h000000;
      default: pixel = {frame_q, 8'h00, ~frame_q};
    endcase
  end

  // Raster counters, bar sub-counter, frame counter and pattern latch.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hcnt      <= '0;
      vcnt      <= '0;
      bar_cnt   <= '0;
      bar_idx   <= '0;
      frame_q   <= '0;
      pattern_q <= '0;
    end else if (!i_enable) begin
      // Frame counter and latched pattern survive a disable; only position restarts.
      hcnt    <= '0;
      vcnt    <= '0;
      bar_cnt <= '0;
      bar_idx <= '0;
    end else begin
      if (at_origin) pattern_q <= i_pattern;
      if (h_last) begin
        hcnt    <= '0;
        bar_cnt <= '0;
        bar_idx <= '0;
        if (v_last) begin
          vcnt    <= '0;
          frame_q <= frame_q + 8'd1;
        end else begin
          vcnt <= vcnt + 16'd1;
        end
      end else begin
        hcnt <= hcnt + 16'd1;
        // Bar index steps every BW active pixels; it wraps 7 -> 0 at end of active.
        if (!hblank) begin
          if (bar_cnt == BW - 16'd1) begin
            bar_cnt <= '0;
            bar_idx <= bar_idx + 3'd1;
          end else begin
            bar_cnt <= bar_cnt + 16'd1;
          end
        end
      end
    end
  end

  // Registered outputs: one cycle behind the counters, idle values while disabled.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      o_pixelData  <= '0;
      o_HSync      <= ~HS_POL;
      o_VSync      <= ~VS_POL;
      o_VDE        <= 1'b0;
      o_HBlank     <= 1'b1;
      o_VBlank     <= 1'b1;
      o_frameStart <= 1'b0;
    end else if (!i_enable) begin
      o_pixelData  <= '0;
      o_HSync      <= ~HS_POL;
      o_VSync      <= ~VS_POL;
      o_VDE        <= 1'b0;
      o_HBlank     <= 1'b1;
      o_VBlank     <= 1'b1;
      o_frameStart <= 1'b0;
    end else begin
      o_pixelData  <= vde ? pixel : 24'h000000;
      o_HSync      <= hsync_act ? HS_POL : ~HS_POL;
      o_VSync      <= vsync_act ? VS_POL : ~VS_POL;
      o_VDE        <= vde;
      o_HBlank     <= hblank;
      o_VBlank     <= vblank;
      o_frameStart <= at_origin;
    end
  end

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Bench for video_timing_pattern_gen with a reduced raster so several frames fit in a short run.
module tb_video_timing_pattern_gen;

  localparam int HA  = 64;
  localparam int HFP = 6;
  localparam int HSY = 4;
  localparam int HBP = 6;
  localparam int VA  = 40;
  localparam int VFP = 2;
  localparam int VSY = 3;
  localparam int VBP = 4;
  localparam bit HSP = 1'b1;
  localparam bit VSP = 1'b0;
  localparam int HT  = HA + HFP + HSY + HBP;
  localparam int VT  = VA + VFP + VSY + VBP;
  localparam int FT  = HT * VT;

  localparam logic [29:0] RST_VEC = {24'h0, ~HSP, ~VSP, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic        Clock = 1'b0;
  logic        Reset;
  logic        i_enable;
  logic [1:0]  i_pattern;
  logic [23:0] o_pixelData;
  logic        o_HSync, o_VSync, o_VDE, o_HBlank, o_VBlank, o_frameStart;

  int total = 0;
  int bad   = 0;

  // Reference model state: raster position, frame number and pattern in force.
  int         mh, mv;
  logic [7:0] mframe;
  logic [1:0] mpat;

  video_timing_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .i_enable     (i_enable),
    .i_pattern    (i_pattern),
    .o_pixelData  (o_pixelData),
    .o_HSync      (o_HSync),
    .o_VSync      (o_VSync),
    .o_VDE        (o_VDE),
    .o_HBlank     (o_HBlank),
    .o_VBlank     (o_VBlank),
    .o_frameStart (o_frameStart)
  );

  always #5 Clock = ~Clock;

  function automatic logic [29:0] model_out(int h, int v, logic [1:0] p, logic [7:0] f);
    logic        hb, vb, de, hs, vs, fs;
    logic [23:0] px;
    hb = (h >= HA);
    vb = (v >= VA);
    de = !hb && !vb;
    hs = (h >= HA + HFP && h < HA + HFP + HSY) ? HSP : ~HSP;
    vs = (v >= VA + VFP && v < VA + VFP + VSY) ? VSP : ~VSP;
    fs = (h == 0 && v == 0);
    px = 24'h0;
    if (de) begin
      case (p)
        2'd0:    px = BARS[h / (HA / 8)];
        2'd1:    px = {3{8'(h)}};
        2'd2:    px = ((((h >> 5) ^ (v >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
        default: px = {f, 8'h00, ~f};
      endcase
    end
    return {px, hs, vs, de, hb, vb, fs};
  endfunction

  function automatic logic [29:0] observed();
    return {o_pixelData, o_HSync, o_VSync, o_VDE, o_HBlank, o_VBlank, o_frameStart};
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; mframe = 8'd0; mpat = 2'd0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; every output is compared against the model.
  task automatic step(input logic en, input logic [1:0] pat);
    logic [29:0] exp_v;
    i_enable  = en;
    i_pattern = pat;
    @(posedge Clock);
    #1;
    if (en) begin
      if (mh == 0 && mv == 0) mpat = pat;
      exp_v = model_out(mh, mv, mpat, mframe);
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv++;
        if (mv == VT) begin
          mv = 0;
          mframe = mframe + 8'd1;
        end
      end
    end else begin
      exp_v = RST_VEC;
      mh = 0;
      mv = 0;
    end
    total++;
    assert (observed() === exp_v)
    else begin
      bad++;
      $error("FAIL step h=%0d v=%0d observed=%h expected=%h", mh, mv, observed(), exp_v);
    end
  endtask

  initial begin
    int vde_n, hs_n, vs_n, fs_n, off;
    logic [1:0] p;
    Reset = 1'b1; i_enable = 1'b0; i_pattern = 2'd0;
    model_reset();
    #12;
    chk("reset_outputs", 32'(observed()), 32'(RST_VEC));
    i_enable = 1'b1;
    Reset = 1'b0;

    // Frame 0: bars, switch request to checker at line 20 (must not tear).
    vde_n = 0; hs_n = 0; vs_n = 0; fs_n = 0;
    for (int k = 0; k < FT; k++) begin
      step(1'b1, (k >= 20 * HT) ? 2'd2 : 2'd0);
      if (o_VDE) vde_n++;
      if (o_HSync == HSP) hs_n++;
      if (o_VSync == VSP) vs_n++;
      if (o_frameStart) fs_n++;
      if (k == 0)  chk("first_frame_start", 32'(o_frameStart), 32'd1);
      if (k == 0)  chk("bar_px0", 32'(o_pixelData), 32'hFFFFFF);
      if (k == 7)  chk("bar_px7", 32'(o_pixelData), 32'hFFFFFF);
      if (k == 8)  chk("bar_px8", 32'(o_pixelData), 32'hFFFF00);
      if (k == 63) chk("bar_px63", 32'(o_pixelData), 32'h000000);
      if (k == 64) chk("vde_fall", 32'(o_VDE), 32'd0);
      if (k == 20 * HT + 32) chk("no_tear", 32'(o_pixelData), 32'hFF00FF);
    end
    chk("vde_cycles", 32'(vde_n), 32'(HA * VA));
    chk("hsync_cycles", 32'(hs_n), 32'(HSY * VT));
    chk("vsync_cycles", 32'(vs_n), 32'(VSY * HT));
    chk("frame_start_count", 32'(fs_n), 32'd1);

    // Frame 1: checker; request frame colour at line 20.
    for (int k = 0; k < FT; k++) begin
      step(1'b1, (k >= 20 * HT) ? 2'd3 : 2'd2);
      if (k == 32) chk("checker_px32", 32'(o_pixelData), 32'hFFFFFF);
    end

    // Frame 2: frame colour with frame counter 2.
    for (int k = 0; k < 3 * HT + 50; k++) begin
      step(1'b1, 2'd3);
      if (k == 0) chk("frame2_colour", 32'(o_pixelData), 32'h0200FD);
    end

    // Drop enable mid-line 3, idle a few cycles, then restart.
    step(1'b0, 2'd3);
    chk("drop_vde", 32'(o_VDE), 32'd0);
    chk("drop_pixel", 32'(o_pixelData), 32'd0);
    for (int k = 0; k < 3; k++) step(1'b0, 2'd3);
    step(1'b1, 2'd3);
    chk("reenable_frame_start", 32'(o_frameStart), 32'd1);

    // Randomised run: occasional enable drops and pattern changes.
    off = 0;
    p = 2'd1;
    for (int k = 0; k < 30000; k++) begin
      if (off == 0 && $urandom_range(499) == 0) off = $urandom_range(5, 1);
      if ($urandom_range(199) == 0) p = 2'($urandom_range(3));
      step(off == 0, p);
      if (off > 0) off--;
    end

    // Asynchronous reset in the middle of a cycle.
    #2;
    Reset = 1'b1;
    #1;
    chk("async_reset", 32'(observed()), 32'(RST_VEC));
    model_reset();
    @(posedge Clock);
    #1;
    chk("reset_held", 32'(observed()), 32'(RST_VEC));
    #2;
    Reset = 1'b0;
    for (int k = 0; k < FT + 100; k++) begin
      if ($urandom_range(299) == 0) p = 2'($urandom_range(3));
      step(1'b1, p);
      if (k == 0) chk("restart_frame_start", 32'(o_frameStart), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
